// File: rtl/ym_dac_deserializer.sv
// YM2151 serial DAC stream receiver: oversamples the asynchronous YM lines in the
// i_clk domain and decodes the 3-bit exponent / 10-bit mantissa words into signed 16-bit PCM.
module ym_dac_deserializer #(
   parameter int SYNC_STAGES = 2,
   parameter int SKIP_BITS   = 3
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_bclk,
   input  logic               i_sdata,
   input  logic               i_sh1,
   input  logic               i_sh2,
   output logic signed [15:0] o_left,
   output logic signed [15:0] o_right,
   output logic               o_l_valid,
   output logic               o_r_valid,
   output logic               o_frame_err,
   output logic               o_locked
);

   localparam int          M_LSB    = SKIP_BITS;
   localparam int          E_LSB    = SKIP_BITS + 10;
   localparam logic [4:0]  WORD_LEN = 5'd16;
   localparam logic [4:0]  CNT_MAX  = 5'd31;

   typedef enum logic {UNSYNC, SYNC} state_t;

   function automatic logic signed [15:0] decode(input logic [9:0] m, input logic [2:0] e);
      logic signed [9:0]  s;
      logic signed [15:0] ext;
      s   = {~m[9], m[8:0]};
      ext = {{6{s[9]}}, s};
      if (e == 3'd0)
         return '0;
      return ext <<< (e - 3'd1);
   endfunction

   logic [SYNC_STAGES-1:0] bclk_sync, sdata_sync, sh1_sync, sh2_sync;
   logic                   bclk_hist, sh1_hist, sh2_hist;

   // Dummy bits shift straight through and are never stored.
   logic [15:SKIP_BITS]    sreg;
   logic [15:SKIP_BITS]    sreg_shifted;
   logic [15:SKIP_BITS]    word_p0;
   logic [4:0]             bitcnt, cnt_inc, cnt_eff;
   logic                   bclk_rise, sh1_fall, sh2_fall, sh_fall;
   logic signed [15:0]     sample_p0;

   state_t                 state, state_nxt;
   logic                   l_upd, r_upd, err;

   // Stage 0: synchronizers and edge history
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bclk_sync  <= '0;
         sdata_sync <= '0;
         sh1_sync   <= '0;
         sh2_sync   <= '0;
         bclk_hist  <= 1'b0;
         sh1_hist   <= 1'b0;
         sh2_hist   <= 1'b0;
      end else begin
         bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i_bclk};
         sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i_sdata};
         sh1_sync   <= {sh1_sync[SYNC_STAGES-2:0], i_sh1};
         sh2_sync   <= {sh2_sync[SYNC_STAGES-2:0], i_sh2};
         bclk_hist  <= bclk_sync[SYNC_STAGES-1];
         sh1_hist   <= sh1_sync[SYNC_STAGES-1];
         sh2_hist   <= sh2_sync[SYNC_STAGES-1];
      end
   end

   assign bclk_rise = bclk_sync[SYNC_STAGES-1] & ~bclk_hist;
   assign sh1_fall  = ~sh1_sync[SYNC_STAGES-1] & sh1_hist;
   assign sh2_fall  = ~sh2_sync[SYNC_STAGES-1] & sh2_hist;
   assign sh_fall   = sh1_fall | sh2_fall;

   // A strobe coinciding with the last bit clock sees the word after that shift.
   assign sreg_shifted = {sdata_sync[SYNC_STAGES-1], sreg[15:SKIP_BITS+1]};
   assign word_p0      = bclk_rise ? sreg_shifted : sreg;
   assign cnt_inc      = (bitcnt == CNT_MAX) ? CNT_MAX : bitcnt + 5'd1;
   assign cnt_eff      = bclk_rise ? cnt_inc : bitcnt;
   assign sample_p0    = decode(word_p0[M_LSB+9:M_LSB], word_p0[E_LSB+2:E_LSB]);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sreg   <= '0;
         bitcnt <= '0;
      end else begin
         if (bclk_rise)
            sreg <= sreg_shifted;
         if (sh_fall)
            bitcnt <= '0;
         else if (bclk_rise)
            bitcnt <= cnt_inc;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         state <= UNSYNC;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      l_upd     = 1'b0;
      r_upd     = 1'b0;
      err       = 1'b0;
      if (sh_fall) begin
         case (state)
            UNSYNC: state_nxt = SYNC;
            SYNC: begin
               if (sh1_fall && sh2_fall)
                  err = 1'b1;
               else if (cnt_eff == WORD_LEN) begin
                  l_upd = sh1_fall;
                  r_upd = sh2_fall;
               end else
                  err = 1'b1;
            end
            default: state_nxt = UNSYNC;
         endcase
      end
   end

   // Stage 1: registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_left      <= '0;
         o_right     <= '0;
         o_l_valid   <= 1'b0;
         o_r_valid   <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_l_valid   <= l_upd;
         o_r_valid   <= r_upd;
         o_frame_err <= err;
         if (l_upd)
            o_left <= sample_p0;
         if (r_upd)
            o_right <= sample_p0;
      end
   end

   assign o_locked = (state == SYNC);

endmodule

// File: tb/tb_ym_dac_deserializer.sv
// Directed bench for ym_dac_deserializer: serial YM words with hand-decoded expected PCM.
module tb_ym_dac_deserializer;

   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic               i_bclk = 1'b0;
   logic               i_sdata = 1'b0;
   logic               i_sh1 = 1'b1;
   logic               i_sh2 = 1'b1;
   logic signed [15:0] o_left, o_right;
   logic               o_l_valid, o_r_valid, o_frame_err, o_locked;

   int  n_checks = 0;
   int  n_fail = 0;
   int  lv_cnt = 0, rv_cnt = 0, err_cnt = 0;
   time last_lv_t = 0, last_fall_t = 0;

   ym_dac_deserializer #(.SYNC_STAGES(2), .SKIP_BITS(3)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_bclk(i_bclk), .i_sdata(i_sdata),
      .i_sh1(i_sh1), .i_sh2(i_sh2), .o_left(o_left), .o_right(o_right),
      .o_l_valid(o_l_valid), .o_r_valid(o_r_valid), .o_frame_err(o_frame_err),
      .o_locked(o_locked)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (o_l_valid === 1'b1) begin
         lv_cnt++;
         last_lv_t = $time;
      end
      if (o_r_valid === 1'b1) rv_cnt++;
      if (o_frame_err === 1'b1) err_cnt++;
   end

   function automatic logic [15:0] mk(input logic [9:0] m, input logic [2:0] e);
      return {e, m, 3'b101};
   endfunction

   // ch: bit0 = SH1, bit1 = SH2, 0 = no strobe. coinc puts the strobe fall on the last bclk rise.
   task automatic send_word(input logic [15:0] w, input int nbits, input int ch, input bit coinc);
      for (int k = 0; k < nbits; k++) begin
         i_sdata = w[k];
         i_bclk  = 1'b0;
         #40;
         i_bclk = 1'b1;
         if (coinc && k == nbits - 1) begin
            last_fall_t = $time;
            if ((ch & 1) != 0) i_sh1 = 1'b0;
            if ((ch & 2) != 0) i_sh2 = 1'b0;
         end
         #40;
      end
      i_bclk = 1'b0;
      if (!coinc && ch != 0) begin
         #20;
         last_fall_t = $time;
         if ((ch & 1) != 0) i_sh1 = 1'b0;
         if ((ch & 2) != 0) i_sh2 = 1'b0;
      end
      #100;
      i_sh1 = 1'b1;
      i_sh2 = 1'b1;
      #40;
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      n_checks++; if (o_left !== 16'h0000) begin n_fail++; $display("FAIL reset_left: got %h expected 0000", o_left); end
      n_checks++; if (o_right !== 16'h0000) begin n_fail++; $display("FAIL reset_right: got %h expected 0000", o_right); end
      n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", o_locked); end
      n_checks++; if (o_l_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lvalid: got %b expected 0", o_l_valid); end
      n_checks++; if (o_r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", o_r_valid); end
      n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", o_frame_err); end
   endtask

   task automatic test_lock();
      int lv0, err0;
      lv0 = lv_cnt; err0 = err_cnt;
      send_word(mk(10'h155, 3'd4), 16, 1, 1'b0);
      n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked: got %b expected 1", o_locked); end
      n_checks++; if (lv_cnt - lv0 != 0) begin n_fail++; $display("FAIL lock_no_valid: got %0d pulses expected 0", lv_cnt - lv0); end
      n_checks++; if (err_cnt - err0 != 0) begin n_fail++; $display("FAIL lock_no_err: got %0d pulses expected 0", err_cnt - err0); end
      lv0 = lv_cnt;
      send_word(mk(10'h3FF, 3'd7), 16, 1, 1'b0);
      n_checks++; if (o_left !== 16'h7FC0) begin n_fail++; $display("FAIL lock_left: got %h expected 7fc0", o_left); end
      n_checks++; if (lv_cnt - lv0 != 1) begin n_fail++; $display("FAIL lock_valid: got %0d pulses expected 1", lv_cnt - lv0); end
      n_checks++; if (last_lv_t - last_fall_t != 30) begin n_fail++; $display("FAIL lock_latency: got %0t expected 30", last_lv_t - last_fall_t); end
   endtask

   task automatic test_decode_sweep();
      logic [9:0]  ms  [4] = '{10'h1FF, 10'h000, 10'h200, 10'h201};
      logic [2:0]  es  [4] = '{3'd0, 3'd1, 3'd5, 3'd3};
      logic [15:0] exps[4] = '{16'h0000, 16'hFE00, 16'h0000, 16'h0004};
      int rv0;
      for (int i = 0; i < 4; i++) begin
         rv0 = rv_cnt;
         send_word(mk(ms[i], es[i]), 16, 2, 1'b0);
         n_checks++; if (o_right !== exps[i]) begin n_fail++; $display("FAIL sweep_right[%0d]: got %h expected %h", i, o_right, exps[i]); end
         n_checks++; if (rv_cnt - rv0 != 1) begin n_fail++; $display("FAIL sweep_valid[%0d]: got %0d pulses expected 1", i, rv_cnt - rv0); end
      end
   endtask

   task automatic test_short_word();
      int lv0, err0;
      lv0 = lv_cnt; err0 = err_cnt;
      send_word(mk(10'h000, 3'd1), 15, 1, 1'b0);
      n_checks++; if (err_cnt - err0 != 1) begin n_fail++; $display("FAIL short_err: got %0d pulses expected 1", err_cnt - err0); end
      n_checks++; if (lv_cnt - lv0 != 0) begin n_fail++; $display("FAIL short_no_valid: got %0d pulses expected 0", lv_cnt - lv0); end
      n_checks++; if (o_left !== 16'h7FC0) begin n_fail++; $display("FAIL short_left_held: got %h expected 7fc0", o_left); end
      lv0 = lv_cnt;
      send_word(mk(10'h210, 3'd2), 16, 1, 1'b0);
      n_checks++; if (o_left !== 16'h0020) begin n_fail++; $display("FAIL short_recover_left: got %h expected 0020", o_left); end
      n_checks++; if (lv_cnt - lv0 != 1) begin n_fail++; $display("FAIL short_recover_valid: got %0d pulses expected 1", lv_cnt - lv0); end
   endtask

   task automatic test_simultaneous();
      int lv0, rv0, err0;
      lv0 = lv_cnt; rv0 = rv_cnt; err0 = err_cnt;
      send_word(mk(10'h3FF, 3'd7), 16, 3, 1'b0);
      n_checks++; if (err_cnt - err0 != 1) begin n_fail++; $display("FAIL simul_err: got %0d pulses expected 1", err_cnt - err0); end
      n_checks++; if (lv_cnt - lv0 != 0) begin n_fail++; $display("FAIL simul_lvalid: got %0d pulses expected 0", lv_cnt - lv0); end
      n_checks++; if (rv_cnt - rv0 != 0) begin n_fail++; $display("FAIL simul_rvalid: got %0d pulses expected 0", rv_cnt - rv0); end
      n_checks++; if (o_left !== 16'h0020) begin n_fail++; $display("FAIL simul_left_held: got %h expected 0020", o_left); end
      n_checks++; if (o_right !== 16'h0004) begin n_fail++; $display("FAIL simul_right_held: got %h expected 0004", o_right); end
   endtask

   task automatic test_coincident();
      int lv0, err0;
      lv0 = lv_cnt; err0 = err_cnt;
      send_word(mk(10'h1C0, 3'd4), 16, 1, 1'b1);
      n_checks++; if (o_left !== 16'hFE00) begin n_fail++; $display("FAIL coinc_left: got %h expected fe00", o_left); end
      n_checks++; if (lv_cnt - lv0 != 1) begin n_fail++; $display("FAIL coinc_valid: got %0d pulses expected 1", lv_cnt - lv0); end
      n_checks++; if (err_cnt - err0 != 0) begin n_fail++; $display("FAIL coinc_no_err: got %0d pulses expected 0", err_cnt - err0); end
   endtask

   task automatic test_midword_reset();
      int rv0, err0;
      send_word(mk(10'h3FF, 3'd7), 8, 0, 1'b0);
      @(negedge i_clk);
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      n_checks++; if (o_left !== 16'h0000) begin n_fail++; $display("FAIL mrst_left: got %h expected 0000", o_left); end
      n_checks++; if (o_right !== 16'h0000) begin n_fail++; $display("FAIL mrst_right: got %h expected 0000", o_right); end
      n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL mrst_locked: got %b expected 0", o_locked); end
      rv0 = rv_cnt; err0 = err_cnt;
      send_word(mk(10'h0F0, 3'd6), 16, 2, 1'b0);
      n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL mrst_relock: got %b expected 1", o_locked); end
      n_checks++; if (rv_cnt - rv0 != 0) begin n_fail++; $display("FAIL mrst_silent_valid: got %0d pulses expected 0", rv_cnt - rv0); end
      n_checks++; if (err_cnt - err0 != 0) begin n_fail++; $display("FAIL mrst_silent_err: got %0d pulses expected 0", err_cnt - err0); end
      rv0 = rv_cnt;
      send_word(mk(10'h201, 3'd3), 16, 2, 1'b0);
      n_checks++; if (o_right !== 16'h0004) begin n_fail++; $display("FAIL mrst_right_sample: got %h expected 0004", o_right); end
      n_checks++; if (rv_cnt - rv0 != 1) begin n_fail++; $display("FAIL mrst_right_valid: got %0d pulses expected 1", rv_cnt - rv0); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_decode_sweep();
      test_short_word();
      test_simultaneous();
      test_coincident();
      test_midword_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
